tpu_rtl_dma_copy_engine: RTL and testbench
==========================================

# tpu_rtl_dma_copy_engine

Parametrised DMA streaming engine for the TPU accelerator tile. It replaces the stub accelerator that only reflected `conf_done` onto `acc_done`. After configuration it moves a region of memory from a source index to a destination index in bursts through the ESP DMA read/write interfaces, staging each burst in an internal FIFO. `acc_done` is raised only after the last beat has been written.

## Interface
Parameters:
- `DMA_WIDTH`, default 64: DMA data bus width in bits; must be 32 or 64; one beat = one word.
- `FIFO_DEPTH`, default 16: staging FIFO depth in beats; power of two, ≥ 2.
- `MAX_BURST`, default 16: largest chunk length in beats; must be ≤ `FIFO_DEPTH`.

Ports:
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `conf_info_reg0` in 32: source index, in words.
- `conf_info_reg1` in 32: destination index, in words.
- `conf_info_reg2` in 32: total length in words.
- `conf_info_reg3` in 32: burst length in words; 0 or > `MAX_BURST` means `MAX_BURST`.
- `conf_info_reg4` in 32: lane addend (used only with the feature in Configuration).
- `conf_done` in 1: one-cycle start pulse; configuration is valid in that cycle.
- `dma_read_ctrl_valid` out 1, `dma_read_ctrl_ready` in 1: read request handshake.
- `dma_read_ctrl_data_index` out 32, `dma_read_ctrl_data_length` out 32, `dma_read_ctrl_data_size` out 3, `dma_read_ctrl_data_user` out 5: read request payload.
- `dma_read_chnl_valid` in 1, `dma_read_chnl_ready` out 1, `dma_read_chnl_data` in `DMA_WIDTH`: read data.
- `dma_write_ctrl_valid` out 1, `dma_write_ctrl_ready` in 1: write request handshake.
- `dma_write_ctrl_data_index` out 32, `dma_write_ctrl_data_length` out 32, `dma_write_ctrl_data_size` out 3, `dma_write_ctrl_data_user` out 5: write request payload.
- `dma_write_chnl_valid` out 1, `dma_write_chnl_ready` in 1, `dma_write_chnl_data` out `DMA_WIDTH`: write data.
- `acc_done` out 1: one-cycle completion pulse.
- `debug` out 32: `{state[3:0], 12'd0, beats_written[15:0]}`.

## Operation
- States: IDLE → RD_REQ → RD_DATA → WR_REQ → WR_DATA → (RD_REQ | DONE) → IDLE.
- IDLE:
  - On `conf_done`, latch src, dst, len and the effective burst; clear the beat counter.
  - If len = 0, go to DONE without issuing any DMA request.
  - `conf_done` in any other state is ignored.
- Chunk length = min(remaining, burst).
- RD_REQ:
  - Drive index = current src, length = chunk, size = 3'b011 (64-bit) or 3'b010 (32-bit), user = 0.
  - Move on when `dma_read_ctrl_valid && dma_read_ctrl_ready`.
- RD_DATA:
  - `dma_read_chnl_ready` = FIFO not full.
  - Each accepted beat is pushed; move on after chunk beats have been pushed.
- WR_REQ: same payload rules with index = current dst.
- WR_DATA:
  - `dma_write_chnl_valid` = FIFO not empty; data = FIFO head (show-ahead).
  - Pop on `valid && ready`.
  - After chunk beats: src += chunk, dst += chunk, remaining -= chunk.
  - Go to RD_REQ if remaining > 0, else DONE.
- DONE: `acc_done` = 1 for exactly one cycle, then IDLE.
- Index arithmetic is 32-bit and wraps modulo 2^32 with no error flag.
- Request payloads are registered and stay stable while valid is high.
- `beats_written` is 16 bits and saturates at 16'hFFFF.

## Timing
- Reset values:
  - All valid and ready outputs 0.
  - All index, length, size and user outputs 0.
  - `acc_done` 0, `debug` 0, state IDLE, FIFO empty.
- `conf_done` in cycle T → `dma_read_ctrl_valid` = 1 in T+1.
- Once valid is asserted, it is held until ready is seen high at a clock edge, and deasserts the cycle after the handshake.
- FIFO push and pop never occur in the same cycle, because read and write phases are disjoint.
- Last write beat accepted in cycle T → `acc_done` high in T+1.
- len = 0: `conf_done` at T → `acc_done` at T+1.
- Asserting `rst` mid-transfer immediately forces IDLE, drops all valids and flushes the FIFO. No partial `acc_done` is produced.
- Back-pressure: a low `dma_write_chnl_ready` stalls the FIFO head with data held constant.

## Configuration
- Macro `TPU_DMA_COPY_ADD_EN`.
- Defined: each 32-bit lane of a beat has `conf_info_reg4` (latched at `conf_done`) added modulo 2^32 on FIFO push. This costs no extra latency.
- Undefined: pure copy; `conf_info_reg4` is ignored and no adder is synthesised.

## Test plan
- src=0x100, dst=0x200, len=4, burst=0, ready always 1 → one read request (index 0x100, length 4, size 3'b011) and one write request (0x200, 4). Written data equals read data. `acc_done` pulses once.
- len=10, burst=4 → read/write lengths 4, 4, 2; write indices dst, dst+4, dst+8; `debug[15:0]` = 10 at done.
- len=0 → no ctrl valid ever asserted; `acc_done` one cycle after `conf_done`.
- Random `dma_write_chnl_ready` low 50% of cycles and `dma_read_chnl_valid` gaps, len=33, burst=16 → data order preserved, no loss or duplication, `acc_done` exactly once.
- `rst` asserted during WR_DATA of a len=8 transfer → all valids 0 immediately; a new `conf_done` (len=2) completes correctly with fresh data.
- With `TPU_DMA_COPY_ADD_EN`, reg4=1, input beat 64'hFFFFFFFF_00000005 → output 64'h00000000_00000006.

Source files
------------

// File: rtl/tpu_rtl_dma_copy_engine_if.sv
// ---------------------------------------------------------------------------
// tpu_rtl_dma_copy_engine_if
// Bundles the ESP DMA read/write control and channel handshakes used by the
// TPU tile copy engine.
//   master : the engine (issues requests, sinks read data, sources write data)
//   slave  : the memory/DMA side (accepts requests, sources read data,
//            sinks write data)
// Signals:
//   dma_read_ctrl_*   : read request valid/ready + index/length/size/user
//   dma_read_chnl_*   : read data valid/ready/data (DMA_WIDTH bits)
//   dma_write_ctrl_*  : write request valid/ready + index/length/size/user
//   dma_write_chnl_*  : write data valid/ready/data (DMA_WIDTH bits)
// ---------------------------------------------------------------------------
interface tpu_rtl_dma_copy_engine_if #(
    parameter int DMA_WIDTH = 64
);
    logic                 dma_read_ctrl_valid;
    logic                 dma_read_ctrl_ready;
    logic [31:0]          dma_read_ctrl_data_index;
    logic [31:0]          dma_read_ctrl_data_length;
    logic [2:0]           dma_read_ctrl_data_size;
    logic [4:0]           dma_read_ctrl_data_user;

    logic                 dma_read_chnl_valid;
    logic                 dma_read_chnl_ready;
    logic [DMA_WIDTH-1:0] dma_read_chnl_data;

    logic                 dma_write_ctrl_valid;
    logic                 dma_write_ctrl_ready;
    logic [31:0]          dma_write_ctrl_data_index;
    logic [31:0]          dma_write_ctrl_data_length;
    logic [2:0]           dma_write_ctrl_data_size;
    logic [4:0]           dma_write_ctrl_data_user;

    logic                 dma_write_chnl_valid;
    logic                 dma_write_chnl_ready;
    logic [DMA_WIDTH-1:0] dma_write_chnl_data;

    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user,
        input  dma_read_ctrl_ready,
        input  dma_read_chnl_valid, dma_read_chnl_data,
        output dma_read_chnl_ready,
        output dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user,
        input  dma_write_ctrl_ready,
        output dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_write_chnl_ready
    );

    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user,
        output dma_read_ctrl_ready,
        output dma_read_chnl_valid, dma_read_chnl_data,
        input  dma_read_chnl_ready,
        input  dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user,
        output dma_write_ctrl_ready,
        input  dma_write_chnl_valid, dma_write_chnl_data,
        output dma_write_chnl_ready
    );
endinterface

// File: rtl/tpu_rtl_dma_copy_engine.sv
// ---------------------------------------------------------------------------
// tpu_rtl_dma_copy_engine
// DMA streaming copy engine for the TPU accelerator tile. After a conf_done
// pulse it copies conf_info_reg2 words from word index conf_info_reg0 to word
// index conf_info_reg1 in bursts of at most conf_info_reg3 words (0 or too
// large means MAX_BURST). Each burst is read into a staging FIFO, then written
// back out. acc_done pulses for one cycle after the last beat is written.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   conf_info_reg0..4 : src index, dst index, length, burst, lane addend
//   conf_done         : one-cycle start pulse (ignored unless idle)
//   dma               : DMA read/write handshakes (master modport)
//   acc_done          : one-cycle completion pulse
//   debug             : {state[3:0], 12'd0, beats_written[15:0]}
//
// Build option: define TPU_DMA_COPY_ADD_EN to add the latched conf_info_reg4
// to every 32-bit lane of each beat as it enters the FIFO. Without it the
// engine is a pure copy and conf_info_reg4 is ignored.
// ---------------------------------------------------------------------------
module tpu_rtl_dma_copy_engine #(
    parameter int DMA_WIDTH  = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] conf_info_reg0,
    input  logic [31:0] conf_info_reg1,
    input  logic [31:0] conf_info_reg2,
    input  logic [31:0] conf_info_reg3,
    input  logic [31:0] conf_info_reg4,
    input  logic        conf_done,
    tpu_rtl_dma_copy_engine_if.master dma,
    output logic        acc_done,
    output logic [31:0] debug
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam int              LANES    = DMA_WIDTH / 32;
    localparam logic [2:0]      SIZE     = (DMA_WIDTH == 64) ? 3'b011 : 3'b010;
    localparam logic [31:0]     MAX_B    = 32'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_REQ  = 4'd1,
        RD_DATA = 4'd2,
        WR_REQ  = 4'd3,
        WR_DATA = 4'd4,
        DONE    = 4'd5
    } state_t;

    function automatic logic [31:0] eff_burst(input logic [31:0] b);
        return (b == 32'd0 || b > MAX_B) ? MAX_B : b;
    endfunction

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t      state;
    logic [31:0] src, dst, remaining, burst, chunk, beat_cnt;
    logic [15:0] beats_written;

    logic        rd_ctrl_valid, wr_ctrl_valid;
    logic [31:0] rd_index, rd_length, wr_index, wr_length;
    logic [2:0]  rd_size, wr_size;

    logic [DMA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 fifo_full, fifo_empty;
    logic                 rd_chnl_ready, wr_chnl_valid, push, pop;
    logic [DMA_WIDTH-1:0] push_data;

    logic [31:0] conf_burst, conf_chunk;
    logic [31:0] src_next, dst_next, rem_next, chunk_next;
    logic        last_rd_beat, last_wr_beat;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // Channel handshakes are decoded from registered state and FIFO level, so
    // they never combinationally depend on the DMA side.
    assign rd_chnl_ready = (state == RD_DATA) && !fifo_full;
    assign wr_chnl_valid = (state == WR_DATA) && !fifo_empty;
    assign push          = rd_chnl_ready && dma.dma_read_chnl_valid;
    assign pop           = wr_chnl_valid && dma.dma_write_chnl_ready;

    assign conf_burst = eff_burst(conf_info_reg3);
    assign conf_chunk = min32(conf_info_reg2, conf_burst);
    assign src_next   = src + chunk;
    assign dst_next   = dst + chunk;
    assign rem_next   = remaining - chunk;
    assign chunk_next = min32(rem_next, burst);

    assign last_rd_beat = push && (beat_cnt == chunk - 32'd1);
    assign last_wr_beat = pop  && (beat_cnt == chunk - 32'd1);

`ifdef TPU_DMA_COPY_ADD_EN
    logic [31:0] addend;

    function automatic logic [DMA_WIDTH-1:0] add_lanes(input logic [DMA_WIDTH-1:0] d,
                                                       input logic [31:0]          a);
        logic [DMA_WIDTH-1:0] r;
        r = d;
        for (int i = 0; i < LANES; i++) begin
            r[i*32 +: 32] = d[i*32 +: 32] + a;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addend <= '0;
        end else if (state == IDLE && conf_done) begin
            addend <= conf_info_reg4;
        end
    end

    // The lane add sits in front of the FIFO write port, so it adds no cycle.
    assign push_data = add_lanes(dma.dma_read_chnl_data, addend);
`else
    logic unused_reg4;
    assign unused_reg4 = ^conf_info_reg4;
    assign push_data   = dma.dma_read_chnl_data;
`endif

    // ---- staging FIFO: storage (no reset, data only) ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // ---- staging FIFO: pointers; read and write phases are disjoint ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end
        end
    end

    // ---- control FSM with registered request payloads and acc_done ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            remaining     <= '0;
            burst         <= '0;
            chunk         <= '0;
            beat_cnt      <= '0;
            beats_written <= '0;
            rd_ctrl_valid <= 1'b0;
            rd_index      <= '0;
            rd_length     <= '0;
            rd_size       <= '0;
            wr_ctrl_valid <= 1'b0;
            wr_index      <= '0;
            wr_length     <= '0;
            wr_size       <= '0;
            acc_done      <= 1'b0;
        end else begin
            acc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (conf_done) begin
                        src           <= conf_info_reg0;
                        dst           <= conf_info_reg1;
                        remaining     <= conf_info_reg2;
                        burst         <= conf_burst;
                        chunk         <= conf_chunk;
                        beat_cnt      <= '0;
                        beats_written <= '0;
                        if (conf_info_reg2 == 32'd0) begin
                            state    <= DONE;
                            acc_done <= 1'b1;
                        end else begin
                            state         <= RD_REQ;
                            rd_ctrl_valid <= 1'b1;
                            rd_index      <= conf_info_reg0;
                            rd_length     <= conf_chunk;
                            rd_size       <= SIZE;
                        end
                    end
                end
                RD_REQ: begin
                    if (rd_ctrl_valid && dma.dma_read_ctrl_ready) begin
                        rd_ctrl_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (last_rd_beat) begin
                        beat_cnt      <= '0;
                        state         <= WR_REQ;
                        wr_ctrl_valid <= 1'b1;
                        wr_index      <= dst;
                        wr_length     <= chunk;
                        wr_size       <= SIZE;
                    end else if (push) begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                WR_REQ: begin
                    if (wr_ctrl_valid && dma.dma_write_ctrl_ready) begin
                        wr_ctrl_valid <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (pop && beats_written != 16'hFFFF) begin
                        beats_written <= beats_written + 16'd1;
                    end
                    if (last_wr_beat) begin
                        src       <= src_next;
                        dst       <= dst_next;
                        remaining <= rem_next;
                        beat_cnt  <= '0;
                        if (rem_next != 32'd0) begin
                            state         <= RD_REQ;
                            chunk         <= chunk_next;
                            rd_ctrl_valid <= 1'b1;
                            rd_index      <= src_next;
                            rd_length     <= chunk_next;
                            rd_size       <= SIZE;
                        end else begin
                            state    <= DONE;
                            acc_done <= 1'b1;
                        end
                    end else if (pop) begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dma.dma_read_ctrl_valid        = rd_ctrl_valid;
    assign dma.dma_read_ctrl_data_index   = rd_index;
    assign dma.dma_read_ctrl_data_length  = rd_length;
    assign dma.dma_read_ctrl_data_size    = rd_size;
    assign dma.dma_read_ctrl_data_user    = 5'd0;
    assign dma.dma_read_chnl_ready        = rd_chnl_ready;

    assign dma.dma_write_ctrl_valid       = wr_ctrl_valid;
    assign dma.dma_write_ctrl_data_index  = wr_index;
    assign dma.dma_write_ctrl_data_length = wr_length;
    assign dma.dma_write_ctrl_data_size   = wr_size;
    assign dma.dma_write_ctrl_data_user   = 5'd0;
    assign dma.dma_write_chnl_valid       = wr_chnl_valid;
    assign dma.dma_write_chnl_data        = mem[rd_ptr];

    assign debug = {state, 12'd0, beats_written};

endmodule

// File: tb/tb_tpu_rtl_dma_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_tpu_rtl_dma_copy_engine
// Scoreboard bench: each transfer pushes its expected read requests, write
// requests and write beats into queues; a memory model answers the DMA side
// and a monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_tpu_rtl_dma_copy_engine;

    localparam int W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg0, reg1, reg2, reg3, reg4;
    logic        conf_done;
    logic        acc_done;
    logic [31:0] debug;

    tpu_rtl_dma_copy_engine_if #(.DMA_WIDTH(W)) dma ();

    tpu_rtl_dma_copy_engine #(
        .DMA_WIDTH (W),
        .FIFO_DEPTH(16),
        .MAX_BURST (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .conf_info_reg0(reg0),
        .conf_info_reg1(reg1),
        .conf_info_reg2(reg2),
        .conf_info_reg3(reg3),
        .conf_info_reg4(reg4),
        .conf_done     (conf_done),
        .dma           (dma.master),
        .acc_done      (acc_done),
        .debug         (debug)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] length;
    } req_t;

    req_t        exp_rreq[$];
    req_t        exp_wreq[$];
    logic [63:0] exp_data[$];
    logic [31:0] rd_beats[$];
    bit          rand_mode = 1'b0;
    int          done_cnt  = 0;
    int          checks    = 0;
    int          passes    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Source memory contents; 0x700 holds the lane-carry test vector.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (a == 32'h700) return 64'hFFFFFFFF_00000005;
        return {~a, a};
    endfunction

    function automatic logic [63:0] exp_word(input logic [31:0] a, input logic [31:0] add);
        logic [63:0] w;
        w = mem_word(a);
`ifdef TPU_DMA_COPY_ADD_EN
        w = {w[63:32] + add, w[31:0] + add};
`endif
        return w;
    endfunction

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] len, input logic [31:0] bl,
                              input logic [31:0] add);
        logic [31:0] eb, rem, s, d, c;
        eb  = (bl == 0 || bl > 16) ? 32'd16 : bl;
        rem = len;
        s   = src;
        d   = dst;
        while (rem > 0) begin
            c = (rem < eb) ? rem : eb;
            exp_rreq.push_back('{index: s, length: c});
            exp_wreq.push_back('{index: d, length: c});
            for (int k = 0; k < int'(c); k++) exp_data.push_back(exp_word(s + 32'(k), add));
            s   = s + c;
            d   = d + c;
            rem = rem - c;
        end
        @(posedge clk); #1;
        reg0 = src; reg1 = dst; reg2 = len; reg3 = bl; reg4 = add;
        conf_done = 1'b1;
        @(posedge clk); #1;
        conf_done = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        #1;
        if (done_cnt == d0) check({name, "_timeout"}, 64'd0, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_queues_drained"},
              64'(exp_rreq.size() + exp_wreq.size() + exp_data.size()), 64'd0);
    endtask

    // Memory / DMA model: samples handshakes at negedge, drives after posedge.
    initial begin
        bit          rq, rb;
        logic [31:0] ridx, rlen;
        dma.dma_read_ctrl_ready  = 1'b1;
        dma.dma_write_ctrl_ready = 1'b1;
        dma.dma_read_chnl_valid  = 1'b0;
        dma.dma_read_chnl_data   = '0;
        dma.dma_write_chnl_ready = 1'b1;
        forever begin
            @(negedge clk);
            rq   = dma.dma_read_ctrl_valid && dma.dma_read_ctrl_ready;
            ridx = dma.dma_read_ctrl_data_index;
            rlen = dma.dma_read_ctrl_data_length;
            rb   = dma.dma_read_chnl_valid && dma.dma_read_chnl_ready;
            @(posedge clk); #1;
            if (rst) begin
                rd_beats.delete();
            end else begin
                if (rb && rd_beats.size() > 0) void'(rd_beats.pop_front());
                if (rq) for (int k = 0; k < int'(rlen) && k < 64; k++) rd_beats.push_back(ridx + 32'(k));
            end
            dma.dma_read_chnl_valid  = (rd_beats.size() > 0) && (!rand_mode || $urandom_range(0, 2) != 0);
            dma.dma_read_chnl_data   = (rd_beats.size() > 0) ? mem_word(rd_beats[0]) : 64'd0;
            dma.dma_write_chnl_ready = !rand_mode || ($urandom_range(0, 1) == 1);
            dma.dma_read_ctrl_ready  = !rand_mode || ($urandom_range(0, 1) == 1);
            dma.dma_write_ctrl_ready = !rand_mode || ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops the scoreboard on every DUT handshake.
    initial begin
        req_t        r;
        logic [63:0] d;
        bit          done_next;
        done_next = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_next = 1'b0;
            end else begin
                if (done_next) begin
                    check("acc_done_after_last_beat", 64'(acc_done), 64'd1);
                    done_next = 1'b0;
                end
                if (acc_done) done_cnt++;
                if (dma.dma_read_ctrl_valid && dma.dma_read_ctrl_ready) begin
                    if (exp_rreq.size() == 0) begin
                        check("unexpected_rd_req", 64'd1, 64'd0);
                    end else begin
                        r = exp_rreq.pop_front();
                        check("rd_index",  64'(dma.dma_read_ctrl_data_index),  64'(r.index));
                        check("rd_length", 64'(dma.dma_read_ctrl_data_length), 64'(r.length));
                        check("rd_size",   64'(dma.dma_read_ctrl_data_size),   64'd3);
                        check("rd_user",   64'(dma.dma_read_ctrl_data_user),   64'd0);
                    end
                end
                if (dma.dma_write_ctrl_valid && dma.dma_write_ctrl_ready) begin
                    if (exp_wreq.size() == 0) begin
                        check("unexpected_wr_req", 64'd1, 64'd0);
                    end else begin
                        r = exp_wreq.pop_front();
                        check("wr_index",  64'(dma.dma_write_ctrl_data_index),  64'(r.index));
                        check("wr_length", 64'(dma.dma_write_ctrl_data_length), 64'(r.length));
                        check("wr_size",   64'(dma.dma_write_ctrl_data_size),   64'd3);
                    end
                end
                if (dma.dma_write_chnl_valid && dma.dma_write_chnl_ready) begin
                    if (exp_data.size() == 0) begin
                        check("unexpected_wr_beat", 64'd1, 64'd0);
                    end else begin
                        d = exp_data.pop_front();
                        check("wr_data", dma.dma_write_chnl_data, d);
                        if (exp_data.size() == 0) done_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; conf_done = 1'b0;
        reg0 = '0; reg1 = '0; reg2 = '0; reg3 = '0; reg4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_ctrl_valid", 64'(dma.dma_read_ctrl_valid),       64'd0);
        check("rst_wr_ctrl_valid", 64'(dma.dma_write_ctrl_valid),      64'd0);
        check("rst_rd_chnl_ready", 64'(dma.dma_read_chnl_ready),       64'd0);
        check("rst_wr_chnl_valid", 64'(dma.dma_write_chnl_valid),      64'd0);
        check("rst_rd_index",      64'(dma.dma_read_ctrl_data_index),  64'd0);
        check("rst_rd_length",     64'(dma.dma_read_ctrl_data_length), 64'd0);
        check("rst_rd_size",       64'(dma.dma_read_ctrl_data_size),   64'd0);
        check("rst_wr_index",      64'(dma.dma_write_ctrl_data_index), 64'd0);
        check("rst_acc_done",      64'(acc_done),                      64'd0);
        check("rst_debug",         64'(debug),                         64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single burst, burst field 0 selects MAX_BURST.
        start_xfer(32'h100, 32'h200, 32'd4, 32'd0, 32'h0000_1000);
        check("t1_rd_valid_after_conf", 64'(dma.dma_read_ctrl_valid), 64'd1);
        wait_done("t1", 200);
        check("t1_debug", 64'(debug), 64'd4);

        // Three chunks: 4, 4, 2.
        start_xfer(32'h1000, 32'h2000, 32'd10, 32'd4, 32'd7);
        wait_done("t2", 400);
        check("t2_debug", 64'(debug), 64'd10);

        // Zero length: acc_done the cycle after conf_done, no requests.
        @(posedge clk); #1;
        reg2 = 32'd0; reg3 = 32'd4; conf_done = 1'b1;
        @(posedge clk); #1;
        conf_done = 1'b0;
        check("t3_acc_done_t1",  64'(acc_done),                  64'd1);
        check("t3_no_rd_valid",  64'(dma.dma_read_ctrl_valid),   64'd0);
        check("t3_no_wr_valid",  64'(dma.dma_write_ctrl_valid),  64'd0);
        @(posedge clk); #1;
        check("t3_acc_done_t2",  64'(acc_done),                  64'd0);
        check("t3_idle",         64'(debug[31:28]),              64'd0);
        check("t3_no_rd_valid2", 64'(dma.dma_read_ctrl_valid),   64'd0);

        // Random back-pressure and read gaps, wrap the address space on dst.
        rand_mode = 1'b1;
        start_xfer(32'h3000, 32'hFFFF_FFF0, 32'd33, 32'd16, 32'h0101_0101);
        wait_done("t4", 4000);
        rand_mode = 1'b0;

        // Reset in the middle of the write phase, then a fresh transfer.
        start_xfer(32'h300, 32'h400, 32'd8, 32'd0, 32'd0);
        for (int i = 0; i < 200 && !(debug[31:28] == 4'd4 && debug[15:0] >= 16'd3); i++) begin
            @(posedge clk); #1;
        end
        check("t5_reached_wr_data", 64'(debug[31:28] == 4'd4), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_rd_ctrl_valid", 64'(dma.dma_read_ctrl_valid),  64'd0);
        check("t5_rst_wr_ctrl_valid", 64'(dma.dma_write_ctrl_valid), 64'd0);
        check("t5_rst_wr_chnl_valid", 64'(dma.dma_write_chnl_valid), 64'd0);
        check("t5_rst_acc_done",      64'(acc_done),                 64'd0);
        check("t5_rst_state",         64'(debug[31:28]),             64'd0);
        exp_rreq.delete();
        exp_wreq.delete();
        exp_data.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_xfer(32'h500, 32'h600, 32'd2, 32'd0, 32'd0);
        wait_done("t5", 200);
        check("t5_debug", 64'(debug), 64'd2);

        // Lane-carry vector: with the addend feature 0xFFFFFFFF_00000005 + 1
        // per lane becomes 0x00000000_00000006; otherwise copied unchanged.
        start_xfer(32'h700, 32'h800, 32'd1, 32'd0, 32'd1);
        wait_done("t6", 200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
